// File: rtl/aes_key_expander.sv
// AES-128 key schedule responder. Latches a cipher key, expands one round
// key per clock into an 11-entry store and serves registered round-key
// requests from the encryption core as soon as the requested key exists.
//
// state  | meaning
// IDLE   | no key loaded since reset, requests are never served
// EXPAND | computing round keys 1..10, one per clock
// READY  | all 11 round keys present in the store
module aes_key_expander #(
  parameter int NO_ROWS   = 4,
  parameter int NO_COLS   = 4,
  parameter int NO_ROUNDS = 10
) (
  input  logic       aes_clk,
  input  logic       resetn,
  input  logic       key_load_i,
  input  logic [7:0] cipher_key_i [NO_ROWS][NO_COLS],
  input  logic       key_req_i,
  input  logic [3:0] key_sel_i,
  output logic       key_vld_o,
  output logic [7:0] round_key_o [NO_ROWS][NO_COLS],
  output logic       key_sel_err_o,
  output logic       busy_o,
  output logic       key_ready_o
);

  localparam int KW = 8 * NO_ROWS * NO_COLS;
  localparam logic [3:0] LAST_RND = 4'(NO_ROUNDS);

  // AES forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t     state;
  logic [3:0] round_cnt;
  logic [3:0] next_idx;
  logic       key_loaded;

  logic [KW-1:0] store [NO_ROUNDS+1];
  logic [KW-1:0] key_in;
  logic [KW-1:0] cur_key;
  logic [KW-1:0] next_key;
  logic [KW-1:0] sel_word;
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot, sub, n0, n1, n2, n3;
  logic [3:0]    sel_idx;
  logic          sel_ok;
  logic          avail;
  logic          serve;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_ROM[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // flatten the key matrix: byte n sits at [n%4][n/4], byte 0 is the MSB
  always_comb begin
    key_in = '0;
    for (int c = 0; c < NO_COLS; c++)
      for (int r = 0; r < NO_ROWS; r++)
        key_in[KW-1-8*(c*NO_ROWS+r) -: 8] = cipher_key_i[r][c];
  end

  // one round of the key schedule applied to the newest stored key
  assign next_idx = round_cnt + 4'd1;
  assign cur_key  = store[round_cnt];
  assign {w0, w1, w2, w3} = cur_key;
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0  = w0 ^ sub ^ {rcon(next_idx), 24'h0};
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // request qualification; a key is servable once the schedule reached it
  assign sel_ok   = (key_sel_i <= LAST_RND);
  assign sel_idx  = sel_ok ? key_sel_i : 4'd0;
  assign sel_word = store[sel_idx];
  assign avail    = key_loaded && (key_sel_i <= round_cnt);
  assign serve    = key_req_i && sel_ok && avail && !key_load_i;

  // sequencing FSM: load restarts from any state, expansion ends on round 10
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      round_cnt   <= '0;
      key_loaded  <= 1'b0;
      busy_o      <= 1'b0;
      key_ready_o <= 1'b0;
    end else if (key_load_i) begin
      state       <= EXPAND;
      round_cnt   <= '0;
      key_loaded  <= 1'b1;
      busy_o      <= 1'b1;
      key_ready_o <= 1'b0;
    end else begin
      case (state)
        EXPAND: begin
          round_cnt <= next_idx;
          if (next_idx == LAST_RND) begin
            state       <= READY;
            busy_o      <= 1'b0;
            key_ready_o <= 1'b1;
          end
        end
        IDLE, READY: ;
        default: state <= IDLE;
      endcase
    end
  end

  // round-key store; contents only matter while key_loaded gates access
  always_ff @(posedge aes_clk) begin
    if (key_load_i)
      store[0] <= key_in;
    else if (state == EXPAND)
      store[next_idx] <= next_key;
  end

  // registered response; round_key_o keeps its last served value otherwise
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      key_vld_o     <= 1'b0;
      key_sel_err_o <= 1'b0;
      for (int r = 0; r < NO_ROWS; r++)
        for (int c = 0; c < NO_COLS; c++)
          round_key_o[r][c] <= 8'h00;
    end else begin
      key_vld_o     <= serve;
      key_sel_err_o <= key_req_i && !sel_ok;
      if (serve) begin
        for (int r = 0; r < NO_ROWS; r++)
          for (int c = 0; c < NO_COLS; c++)
            round_key_o[r][c] <= sel_word[KW-1-8*(c*NO_ROWS+r) -: 8];
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander. The reference key schedule is
// built from GF(2^8) arithmetic (S-box from field inverse + affine map).
module tb_aes_key_expander;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK5 = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;

  logic       aes_clk = 1'b0;
  logic       resetn;
  logic       key_load_i;
  logic [7:0] cipher_key_i [4][4];
  logic       key_req_i;
  logic [3:0] key_sel_i;
  logic       key_vld_o;
  logic [7:0] round_key_o [4][4];
  logic       key_sel_err_o;
  logic       busy_o;
  logic       key_ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sb  [256];
  logic [127:0] mrk [11];

  typedef struct {
    logic [3:0]   sel;
    logic         vld;
    logic         err;
    logic [127:0] rk;
  } vec_t;
  vec_t vecs [5];

  always #5 aes_clk = ~aes_clk;

  aes_key_expander #(.NO_ROWS(4), .NO_COLS(4), .NO_ROUNDS(10)) dut (
    .aes_clk       (aes_clk),
    .resetn        (resetn),
    .key_load_i    (key_load_i),
    .cipher_key_i  (cipher_key_i),
    .key_req_i     (key_req_i),
    .key_sel_i     (key_sel_i),
    .key_vld_o     (key_vld_o),
    .round_key_o   (round_key_o),
    .key_sel_err_o (key_sel_err_o),
    .busy_o        (busy_o),
    .key_ready_o   (key_ready_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = {a[6:0], 1'b0} ^ 8'h1b;
      else      a = {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) mrk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic set_key(input logic [127:0] k);
    for (int n = 0; n < 16; n++) cipher_key_i[n % 4][n / 4] = k[127-8*n -: 8];
  endtask

  function automatic logic [127:0] rk_now();
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = round_key_o[n % 4][n / 4];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aes_clk);
    #1;
  endtask

  task automatic wait_ready(input int lim);
    int c;
    c = 0;
    while (!key_ready_o && c < lim) begin
      tick();
      c++;
    end
    chk("wait_ready", key_ready_o, 1);
  endtask

  task automatic load_key(input logic [127:0] k);
    set_key(k);
    key_load_i = 1'b1;
    tick();
    key_load_i = 1'b0;
  endtask

  initial begin
    logic [127:0] k, exp_rk;
    logic ev, ee;

    vecs[0] = '{sel: 4'd1,  vld: 1'b1, err: 1'b0, rk: FIPS_RK1};
    vecs[1] = '{sel: 4'd10, vld: 1'b1, err: 1'b0, rk: FIPS_RK10};
    vecs[2] = '{sel: 4'd0,  vld: 1'b1, err: 1'b0, rk: FIPS_KEY};
    vecs[3] = '{sel: 4'd5,  vld: 1'b1, err: 1'b0, rk: FIPS_RK5};
    vecs[4] = '{sel: 4'd11, vld: 1'b0, err: 1'b1, rk: FIPS_RK5};

    build_sbox();
    resetn = 1'b1; key_load_i = 1'b0; key_req_i = 1'b0; key_sel_i = 4'd0;
    set_key('0);
    #2 resetn = 1'b0;
    repeat (2) tick();
    chk("rst_vld", key_vld_o, 0);
    chk("rst_err", key_sel_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", key_ready_o, 0);
    chk("rst_rk", rk_now(), 0);
    resetn = 1'b1;

    // requests before any key was loaded
    key_req_i = 1'b1; key_sel_i = 4'd0;
    repeat (3) begin tick(); chk("noload_vld", key_vld_o, 0); end
    key_req_i = 1'b0;

    // FIPS key: expansion timing with sel=5 held from the first edge after load
    build_model(FIPS_KEY);
    set_key(FIPS_KEY);
    key_load_i = 1'b1;
    tick();
    chk("load_busy", busy_o, 1);
    chk("load_ready", key_ready_o, 0);
    key_load_i = 1'b0; key_req_i = 1'b1; key_sel_i = 4'd5;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("early_vld", key_vld_o, (i >= 6));
      chk("exp_busy", busy_o, (i <= 9));
      chk("exp_ready", key_ready_o, (i >= 10));
      if (i >= 6) chk("early_rk5", rk_now(), FIPS_RK5);
    end

    // table of FIPS request vectors after ready
    for (int v = 0; v < 5; v++) begin
      key_sel_i = vecs[v].sel;
      tick();
      chk("vec_vld", key_vld_o, vecs[v].vld);
      chk("vec_err", key_sel_err_o, vecs[v].err);
      chk("vec_rk", rk_now(), vecs[v].rk);
    end

    // held request while the index sweeps 0..10, then out of range
    for (int s = 0; s <= 10; s++) begin
      key_sel_i = 4'(s);
      tick();
      chk("sweep_vld", key_vld_o, 1);
      chk("sweep_err", key_sel_err_o, 0);
      chk("sweep_rk", rk_now(), mrk[s]);
    end
    key_sel_i = 4'd11;
    tick();
    chk("sel11_err", key_sel_err_o, 1);
    chk("sel11_vld", key_vld_o, 0);
    chk("sel11_hold", rk_now(), mrk[10]);
    key_req_i = 1'b0;
    tick();
    chk("err_pulse", key_sel_err_o, 0);

    // reload with zero key at round_cnt=4, colliding with a sel=2 request
    load_key(FIPS_KEY);
    repeat (4) tick();
    set_key('0);
    key_load_i = 1'b1; key_req_i = 1'b1; key_sel_i = 4'd2;
    tick();
    chk("reload_vld", key_vld_o, 0);
    chk("reload_busy", busy_o, 1);
    key_load_i = 1'b0; key_sel_i = 4'd5;
    tick();
    chk("stale_vld", key_vld_o, 0);
    key_sel_i = 4'd0;
    tick();
    chk("new_k0_vld", key_vld_o, 1);
    chk("new_k0_rk", rk_now(), 0);
    key_req_i = 1'b0;
    wait_ready(15);
    key_req_i = 1'b1; key_sel_i = 4'd1;
    tick();
    chk("zero_vld", key_vld_o, 1);
    chk("zero_rk1", rk_now(), ZERO_RK1);
    key_req_i = 1'b0;

    // asynchronous reset during expansion
    load_key(FIPS_KEY);
    key_req_i = 1'b1; key_sel_i = 4'd0;
    repeat (6) tick();
    chk("pre_rst_busy", busy_o, 1);
    chk("pre_rst_rk", rk_now(), FIPS_KEY);
    resetn = 1'b0;
    #1;
    chk("mid_rst_vld", key_vld_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", key_ready_o, 0);
    chk("mid_rst_err", key_sel_err_o, 0);
    chk("mid_rst_rk", rk_now(), 0);
    tick();
    resetn = 1'b1;
    repeat (3) begin tick(); chk("post_rst_vld", key_vld_o, 0); end
    chk("post_rst_busy", busy_o, 0);
    key_req_i = 1'b0;

    // randomized keys and requests against the reference schedule
    for (int it = 0; it < 4; it++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      build_model(k);
      load_key(k);
      wait_ready(15);
      key_req_i = 1'b1; key_sel_i = 4'd0;
      tick();
      exp_rk = mrk[0];
      chk("rnd_k0_vld", key_vld_o, 1);
      chk("rnd_k0_rk", rk_now(), exp_rk);
      for (int j = 0; j < 16; j++) begin
        key_req_i = 1'($urandom_range(0, 1));
        key_sel_i = 4'($urandom_range(0, 15));
        tick();
        ev = key_req_i && (key_sel_i <= 4'd10);
        ee = key_req_i && (key_sel_i > 4'd10);
        if (ev) exp_rk = mrk[key_sel_i];
        chk("rnd_vld", key_vld_o, ev);
        chk("rnd_err", key_sel_err_o, ee);
        chk("rnd_rk", rk_now(), exp_rk);
      end
      key_req_i = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
